barker_frame_sync: RTL and testbench
====================================

# barker_frame_sync

Frame synchronizer that sequences the Barker-11 correlator's per-bit detections into a frame lock. It sits directly downstream of the correlator. It takes the received bit stream with each bit tagged by the correlator hit flag, runs a HUNT/VERIFY/LOCK state machine against a fixed frame period, and forwards only payload bits while locked. It is the control point that decides when correlator hits are trusted.

## Interface
- FRAME_LEN, 64: bits per frame, sync word included; must be ≥ 13.
- SYNC_LEN, 11: sync word length; payload bits per frame = FRAME_LEN − SYNC_LEN.
- VERIFY_CNT, 2: consecutive on-time hits, including the first, required to lock; must be ≥ 2.
- MISS_MAX, 3: consecutive missed syncs in LOCK that cause loss of lock; must be ≥ 1.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- s_tdata  in  1  received bit.
- s_tuser  in  1  correlator hit: sync word ends on this bit.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input beat accepted when s_tvalid && s_tready.
- m_tdata  out  1  payload bit.
- m_tvalid  out  1  payload beat valid.
- m_tlast  out  1  last payload bit of the frame.
- m_tready  in  1  downstream ready.
- o_locked  out  1  high while in LOCK.
- o_state  out  2  HUNT=0, VERIFY=1, LOCK=2.
- o_lock_cnt  out  16  lock acquisitions (see Configuration).
- o_loss_cnt  out  16  lock losses (see Configuration).

## Operation
- Position counter p runs 0..FRAME_LEN−1. p=0 is the first bit after a sync end. The expected sync-end beat is p=FRAME_LEN−1, where p wraps to 0.
- All state, counters and p change only on accepted beats.
- **HUNT**
  - p is idle.
  - A beat with s_tuser=1 sets p=0 and good=1, then goes to VERIFY.
- **VERIFY**
  - p increments every beat. Hits at other positions are ignored.
  - At p=FRAME_LEN−1 with s_tuser=1: good+1. If good reaches VERIFY_CNT, go to LOCK with miss=0; otherwise stay in VERIFY.
  - At p=FRAME_LEN−1 with s_tuser=0: go to HUNT.
- **LOCK**
  - Beats at p=0..FRAME_LEN−SYNC_LEN−1 are forwarded to m_tdata. m_tlast=1 at p=FRAME_LEN−SYNC_LEN−1.
  - Sync-position beats are consumed and not forwarded.
  - At p=FRAME_LEN−1: a hit sets miss=0. No hit increments miss; when miss reaches MISS_MAX, go to HUNT.
  - Off-position hits are ignored; there is no re-alignment while locked.
- The beat that enters LOCK is a sync beat. Forwarding starts with the next beat.
- The beat that exits LOCK is never forwarded.
- Width rules:
  - p is $clog2(FRAME_LEN) bits.
  - good and miss are sized to their maximum and never wrap.

## Timing
- s_tready = !m_tvalid || m_tready, in every state.
- Forwarded payload appears one cycle after acceptance: single output register.
- m_tvalid, m_tdata and m_tlast hold while m_tvalid && !m_tready.
- o_state and o_locked are registered. They update in the cycle after the deciding beat.
- Reset values:
  - state=HUNT, p=0, good=0, miss=0.
  - m_tvalid=0, m_tdata=0, m_tlast=0.
  - o_locked=0, o_state=0, both statistics counters=0.
- Reset asserted mid-frame clears everything immediately, including an unconsumed m beat.
- After reset, lock requires a fresh HUNT hit.
- An output beat pending when LOCK exits still completes normally.

## Configuration
- Macro: BARKER_FSYNC_STATS_EN.
- Defined:
  - o_lock_cnt increments on every VERIFY→LOCK transition.
  - o_loss_cnt increments on every LOCK→HUNT transition.
  - Both counters saturate at 16'hFFFF and are cleared only by reset.
- Undefined: the counter logic is absent and both ports are driven constant 0.

## Test plan
Parameters for all scenarios: FRAME_LEN=32, SYNC_LEN=11, VERIFY_CNT=2, MISS_MAX=3.
- Reset with s_tvalid=1 → all outputs 0, o_state=0, and no m_tvalid until lock.
- Hits on beats 0 and 32 → o_state=1 after beat 0, o_state=2 and o_locked=1 after beat 32. Beats 33..53 forwarded (21 bits) with m_tlast on beat 53. Beats 54..64 not forwarded.
- Hit on beat 0, no hit on beat 32, hit on beat 40 → HUNT after beat 32, VERIFY again after beat 40.
- Locked stream, syncs missing in 2 frames then present → o_locked stays 1. Then 3 consecutive misses → o_state=0, o_locked=0 in the cycle after the third expected position, and no further m_tvalid.
- m_tready low for 5 cycles mid-payload → s_tready low and m_tdata/m_tlast held. All 21 payload bits delivered in order: no loss, no duplicate.
- BARKER_FSYNC_STATS_EN defined, lock → loss → lock → o_lock_cnt=2, o_loss_cnt=1. Macro undefined → both counters read 0.

Source files
------------

// File: rtl/barker_frame_sync.sv
// barker_frame_sync: HUNT/VERIFY/LOCK frame synchronizer behind a Barker-11 correlator.
// Forwards only payload bits while locked, through a single output register.
// Optional lock/loss statistics are built when BARKER_FSYNC_STATS_EN is defined;
// otherwise o_lock_cnt/o_loss_cnt are tied to zero.
module barker_frame_sync #(
    parameter int unsigned FRAME_LEN  = 64,
    parameter int unsigned SYNC_LEN   = 11,
    parameter int unsigned VERIFY_CNT = 2,
    parameter int unsigned MISS_MAX   = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        s_tdata,
    input  logic        s_tuser,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic        m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    input  logic        m_tready,
    output logic        o_locked,
    output logic [1:0]  o_state,
    output logic [15:0] o_lock_cnt,
    output logic [15:0] o_loss_cnt
);

    localparam int unsigned PW = $clog2(FRAME_LEN);
    localparam int unsigned GW = $clog2(VERIFY_CNT + 1);
    localparam int unsigned MW = $clog2(MISS_MAX + 1);

    localparam logic [PW-1:0] P_LAST     = PW'(FRAME_LEN - 1);
    localparam logic [PW-1:0] P_PAY_LAST = PW'(FRAME_LEN - SYNC_LEN - 1);
    localparam logic [GW-1:0] GOOD_LIM   = GW'(VERIFY_CNT);
    localparam logic [MW-1:0] MISS_LIM   = MW'(MISS_MAX);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCK   = 2'd2;

    logic [1:0]    state, state_n;
    logic [PW-1:0] p, p_n, p_adv;
    logic [GW-1:0] good, good_n;
    logic [MW-1:0] miss, miss_n;
    logic          m_tvalid_n, m_tdata_n, m_tlast_n, locked_n;
    logic          accept;
    logic          enter_lock, lose_lock;

    assign s_tready = !m_tvalid || m_tready;
    assign accept   = s_tvalid && s_tready;
    assign p_adv    = (p == P_LAST) ? '0 : p + PW'(1);
    assign o_state  = state;

    // State, position, counters and output register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_HUNT;
            p        <= '0;
            good     <= '0;
            miss     <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= 1'b0;
            m_tlast  <= 1'b0;
            o_locked <= 1'b0;
        end else begin
            state    <= state_n;
            p        <= p_n;
            good     <= good_n;
            miss     <= miss_n;
            m_tvalid <= m_tvalid_n;
            m_tdata  <= m_tdata_n;
            m_tlast  <= m_tlast_n;
            o_locked <= locked_n;
        end
    end

    // Next-state: sync tracking and payload forwarding on accepted beats
    always_comb begin
        state_n    = state;
        p_n        = p;
        good_n     = good;
        miss_n     = miss;
        m_tvalid_n = m_tvalid && !m_tready;
        m_tdata_n  = m_tdata;
        m_tlast_n  = m_tlast;
        enter_lock = 1'b0;
        lose_lock  = 1'b0;
        if (accept) begin
            case (state)
                ST_HUNT: begin
                    if (s_tuser) begin
                        p_n     = '0;
                        good_n  = GW'(1);
                        state_n = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    p_n = p_adv;
                    if (p == P_LAST) begin
                        if (!s_tuser) begin
                            good_n  = '0;
                            state_n = ST_HUNT;
                        end else if (good == GOOD_LIM - GW'(1)) begin
                            good_n     = '0;
                            miss_n     = '0;
                            state_n    = ST_LOCK;
                            enter_lock = 1'b1;
                        end else begin
                            good_n = good + GW'(1);
                        end
                    end
                end
                ST_LOCK: begin
                    p_n = p_adv;
                    if (p <= P_PAY_LAST) begin
                        m_tvalid_n = 1'b1;
                        m_tdata_n  = s_tdata;
                        m_tlast_n  = (p == P_PAY_LAST);
                    end
                    if (p == P_LAST) begin
                        if (s_tuser) begin
                            miss_n = '0;
                        end else if (miss == MISS_LIM - MW'(1)) begin
                            miss_n    = '0;
                            state_n   = ST_HUNT;
                            lose_lock = 1'b1;
                        end else begin
                            miss_n = miss + MW'(1);
                        end
                    end
                end
                default: begin
                    state_n = ST_HUNT;
                    p_n     = '0;
                    good_n  = '0;
                    miss_n  = '0;
                end
            endcase
        end
        locked_n = (state_n == ST_LOCK);
    end

`ifdef BARKER_FSYNC_STATS_EN
    logic [15:0] lock_cnt, loss_cnt;

    // Saturating lock acquisition / loss statistics
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_cnt <= '0;
            loss_cnt <= '0;
        end else begin
            if (enter_lock && (lock_cnt != 16'hFFFF)) lock_cnt <= lock_cnt + 16'd1;
            if (lose_lock && (loss_cnt != 16'hFFFF))  loss_cnt <= loss_cnt + 16'd1;
        end
    end

    assign o_lock_cnt = lock_cnt;
    assign o_loss_cnt = loss_cnt;
`else
    logic unused_stats;
    assign unused_stats = enter_lock ^ lose_lock;
    assign o_lock_cnt   = '0;
    assign o_loss_cnt   = '0;
`endif

endmodule

// File: tb/tb_barker_frame_sync.sv
// Bench for barker_frame_sync with FRAME_LEN=32, SYNC_LEN=11, VERIFY_CNT=2, MISS_MAX=3.
// Per-beat vector tables give state expectations; forwarded payload is scoreboarded.
module tb_barker_frame_sync;

    localparam int unsigned FL = 32;
    localparam int unsigned SL = 11;
    localparam int unsigned VC = 2;
    localparam int unsigned MM = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_tdata = 1'b0, s_tuser = 1'b0, s_tvalid = 1'b0;
    logic        s_tready;
    logic        m_tdata, m_tvalid, m_tlast;
    logic        m_tready = 1'b1;
    logic        o_locked;
    logic [1:0]  o_state;
    logic [15:0] o_lock_cnt, o_loss_cnt;

    barker_frame_sync #(
        .FRAME_LEN(FL), .SYNC_LEN(SL), .VERIFY_CNT(VC), .MISS_MAX(MM)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .o_locked(o_locked), .o_state(o_state),
        .o_lock_cnt(o_lock_cnt), .o_loss_cnt(o_loss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       data;
        bit       user;
        bit [1:0] st;
        bit       fwd;
        bit       last;
    } vec_t;

    typedef struct {
        bit data;
        bit last;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic void add_vec(input bit user, input bit [1:0] st, input bit fwd, input bit last);
        vec_t v;
        v.data = 1'($urandom_range(0, 1));
        v.user = user;
        v.st   = st;
        v.fwd  = fwd;
        v.last = last;
        vecs.push_back(v);
    endfunction

    // Output monitor: scoreboard compare on handshake, hold check while stalled
    bit   hold_pend = 1'b0;
    logic hold_d, hold_l;
    exp_t e;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", m_tvalid, 1);
                check("hold_data", m_tdata, hold_d);
                check("hold_last", m_tlast, hold_l);
            end
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", m_tvalid, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", m_tdata, e.data);
                    check("out_last", m_tlast, e.last);
                end
            end
            hold_pend = m_tvalid && !m_tready;
            hold_d    = m_tdata;
            hold_l    = m_tlast;
        end
    end

    // Offer one beat, bounded wait for acceptance; returns at posedge+1
    task automatic send(input bit d, input bit u, output bit ok);
        ok = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = u;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = s_tready;
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic stall5();
        m_tready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_s_tready", s_tready, 0);
            @(posedge clk);
            #1;
        end
        m_tready = 1'b1;
    endtask

    task automatic run_vecs(input string tag, input int stall_idx);
        bit ok;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i == stall_idx) stall5();
            send(vecs[i].data, vecs[i].user, ok);
            check($sformatf("%s_accept_b%0d", tag, i), ok, 1);
            if (ok && vecs[i].fwd) sb.push_back('{data: vecs[i].data, last: vecs[i].last});
            check($sformatf("%s_state_b%0d", tag, i), o_state, vecs[i].st);
            check($sformatf("%s_locked_b%0d", tag, i), o_locked, (vecs[i].st == 2'd2));
        end
    endtask

    task automatic drain(input string tag);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    // Reset with a live hit beat on the input; everything must read zero
    task automatic do_reset();
        rst_n    = 1'b0;
        s_tvalid = 1'b1;
        s_tuser  = 1'b1;
        s_tdata  = 1'b1;
        m_tready = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_state", o_state, 0);
        check("rst_locked", o_locked, 0);
        check("rst_lock_cnt", o_lock_cnt, 0);
        check("rst_loss_cnt", o_loss_cnt, 0);
        check("rst_s_tready", s_tready, 1);
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_state", o_state, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        do_reset();

        // Lock on hits at beats 0 and 32; payload 33..53, sync 54..64; stall mid-payload
        vecs.delete();
        for (int b = 0; b <= 64; b++)
            add_vec(b == 0 || b == 32 || b == 64, (b < 32) ? 2'd1 : 2'd2,
                    b >= 33 && b <= 53, b == 53);
        run_vecs("lock", 40);
        drain("lock");

        // Unconsumed output beat is wiped by an asynchronous reset
        m_tready = 1'b0;
        send(1'b1, 1'b0, ok);
        check("pend_accept", ok, 1);
        check("pend_valid", m_tvalid, 1);
        check("pend_data", m_tdata, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", m_tvalid, 0);
        check("async_rst_data", m_tdata, 0);
        check("async_rst_state", o_state, 0);
        check("async_rst_locked", o_locked, 0);
        do_reset();

        // Fresh hunt needed; off-position hit ignored; missing verify sync returns to HUNT
        vecs.delete();
        for (int b = 0; b <= 47; b++)
            add_vec(b == 3 || b == 13 || b == 43,
                    (b < 3) ? 2'd0 : (b < 35) ? 2'd1 : (b < 43) ? 2'd0 : 2'd1, 1'b0, 1'b0);
        run_vecs("verify", -1);
        drain("verify");
        do_reset();

        // Miss tolerance, loss after three misses, then relock
        vecs.delete();
        for (int b = 0; b <= 276; b++) begin
            bit in_lock1;
            int pos;
            in_lock1 = (b >= 33 && b <= 223);
            pos = (b - 33) % 32;
            add_vec(b == 0 || b == 32 || b == 128 || b == 140 || b == 241 || b == 273,
                    (b < 32) ? 2'd1 : (b < 224) ? 2'd2 : (b < 241) ? 2'd0 : (b < 273) ? 2'd1 : 2'd2,
                    (in_lock1 && pos <= 20) || b >= 274,
                    in_lock1 && pos == 20);
        end
        run_vecs("miss", -1);
        drain("miss");
`ifdef BARKER_FSYNC_STATS_EN
        check("stat_lock_cnt", o_lock_cnt, 2);
        check("stat_loss_cnt", o_loss_cnt, 1);
`else
        check("stat_lock_cnt", o_lock_cnt, 0);
        check("stat_loss_cnt", o_loss_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
